// File: rtl/sha256_round_rewind.sv
// Iterative inverse SHA-256 compression: walks the round function backwards,
// one round per accepted W/K beat, from a post-compression working state.
module sha256_round_rewind #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [255:0] state_i,
    input  logic         wk_valid_i,
    input  logic [31:0]  w_i,
    input  logic [31:0]  k_i,
    output logic         wk_ready_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [255:0] state_o,
    output logic [5:0]   round_o
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ROUND_W = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } fsm_t;

    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic [WORD_W-1:0] c;
        logic [WORD_W-1:0] d;
        logic [WORD_W-1:0] e;
        logic [WORD_W-1:0] f;
        logic [WORD_W-1:0] g;
        logic [WORD_W-1:0] h;
    } work_t;

    fsm_t  fsm;
    work_t cur;
    work_t inv;
    logic [WORD_W-1:0] s0, maj, t2, t1, s1, ch;

    function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    assign cur = work_t'(state_o);

    // Undo one forward round: shifted words move back, T1/T2 are recovered
    // from the new a and then peeled off e and h.
    always_comb begin
        inv   = '0;
        inv.a = cur.b;
        inv.b = cur.c;
        inv.c = cur.d;
        inv.e = cur.f;
        inv.f = cur.g;
        inv.g = cur.h;
        s0    = big_sigma0(inv.a);
        maj   = (inv.a & inv.b) ^ (inv.a & inv.c) ^ (inv.b & inv.c);
        t2    = s0 + maj;
        t1    = cur.a - t2;
        inv.d = cur.e - t1;
        s1    = big_sigma1(inv.e);
        ch    = (inv.e & inv.f) ^ (~inv.e & inv.g);
        inv.h = t1 - s1 - ch - k_i - w_i;
    end

    // Control FSM; status outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm        <= S_IDLE;
            state_o    <= '0;
            round_o    <= '0;
            done_o     <= 1'b0;
            busy_o     <= 1'b0;
            wk_ready_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (fsm)
                S_IDLE: begin
                    if (start_i) begin
                        fsm        <= S_RUN;
                        state_o    <= state_i;
                        round_o    <= ROUND_W'(ROUNDS - 1);
                        busy_o     <= 1'b1;
                        wk_ready_o <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (wk_valid_i && wk_ready_o) begin
                        state_o <= inv;
                        if (round_o == '0) begin
                            fsm        <= S_DONE;
                            wk_ready_o <= 1'b0;
                            done_o     <= 1'b1;
                        end else begin
                            round_o <= round_o - ROUND_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    fsm    <= S_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    fsm        <= S_IDLE;
                    busy_o     <= 1'b0;
                    wk_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
